// File: rtl/spi_xip_pkg.sv
// Shared constants and types for the APB-to-Wishbone XIP front end of spi_top.
package spi_xip_pkg;

  // Sequencer states (plain constants so the encoding stays fixed across tools).
  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_PASS    = 4'd1;
  localparam state_t ST_ERR     = 4'd2;
  localparam state_t ST_W_DIV   = 4'd3;
  localparam state_t ST_W_SS    = 4'd4;
  localparam state_t ST_W_TX1   = 4'd5;
  localparam state_t ST_W_TX0   = 4'd6;
  localparam state_t ST_W_GO    = 4'd7;
  localparam state_t ST_POLL    = 4'd8;
  localparam state_t ST_R_RX    = 4'd9;
  localparam state_t ST_W_SSOFF = 4'd10;
  localparam state_t ST_RESP    = 4'd11;

  // spi_top register offsets.
  localparam logic [4:0] REG_RX0  = 5'h00;
  localparam logic [4:0] REG_TX0  = 5'h00;
  localparam logic [4:0] REG_TX1  = 5'h04;
  localparam logic [4:0] REG_CTRL = 5'h10;
  localparam logic [4:0] REG_DIV  = 5'h14;
  localparam logic [4:0] REG_SS   = 5'h18;

  localparam int          CTRL_GO_BIT    = 8;
  // CHAR_LEN 64, GO (bit 8), ASS (bit 13).
  localparam logic [31:0] XIP_CTRL       = 32'h0000_2140;
  localparam logic [7:0]  FLASH_READ_CMD = 8'h03;

  // One Wishbone sub-access request.
  typedef struct packed {
    logic [4:0]  adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } wb_req_t;

  // The flash shifts its first byte into the MSB of RX0; return it in byte lane 0.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/spi_xip_wb_req.sv
// Single Wishbone request holder: launches one access on start_i, holds it until ack,
// then drops every output to zero for at least one cycle.
module spi_xip_wb_req
  import spi_xip_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [4:0]  req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_sel_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  wb_req_t req_q;
  logic    stb_q;

  // Hold the request from launch until the ack cycle, then clear it.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    if (!reset) begin
      req_q <= '0;
      stb_q <= 1'b0;
    end else if (stb_q && wb_ack_i) begin
      req_q <= '0;
      stb_q <= 1'b0;
    end else if (start_i && !stb_q) begin
      req_q <= '{adr: req_adr_i, dat: req_dat_i, we: req_we_i, sel: req_sel_i};
      stb_q <= 1'b1;
    end
  end

  assign wb_adr_o = req_q.adr;
  assign wb_dat_o = req_q.dat;
  assign wb_we_o  = req_q.we;
  assign wb_sel_o = req_q.sel;
  assign wb_stb_o = stb_q;
  assign wb_cyc_o = stb_q;

  assign busy_o  = stb_q;
  assign done_o  = stb_q & wb_ack_i;
  assign err_o   = wb_err_i;
  assign rdata_o = wb_dat_i;

endmodule

// File: rtl/spi_xip_seq.sv
// APB front end for spi_top: SPI-window accesses pass through as one Wishbone access,
// flash-window reads run a fixed cmd 0x03 + addr + 32-bit XIP read on the SPI master.
module spi_xip_seq
  import spi_xip_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
  parameter logic [31:0] SPI_END    = 32'h1000_1fff,
  parameter logic [31:0] XIP_DIV    = 32'h0000_0001,
  parameter logic [7:0]  XIP_SS     = 8'h01,
  parameter int          POLL_MAX   = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int                CNT_W     = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0]  POLL_LAST = CNT_W'(POLL_MAX - 1);

  state_t            state_q, state_d;
  logic [23:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic              err_q, err_d;
  logic [31:0]       data_q, data_d;
  logic              pready_q, pready_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  wb_req_t     req;
  logic        req_active;
  logic        req_busy, req_done, req_err;
  logic [31:0] req_rdata;

  logic in_flash, in_spi, accept;
  assign in_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign in_spi   = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_END);
  assign accept   = in_psel && !in_penable;

  // Sequencer next state: pick the sub-access for this state and advance on its ack.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    write_d    = write_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    data_d     = data_q;
    pready_d   = 1'b0;
    prdata_d   = '0;
    pslverr_d  = 1'b0;
    req        = '0;
    req_active = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d     = in_paddr[23:0];
          wdata_d    = in_pwdata;
          strb_d     = in_pstrb;
          write_d    = in_pwrite;
          poll_cnt_d = '0;
          err_d      = 1'b0;
          data_d     = '0;
          if (in_spi)                     state_d = ST_PASS;
          else if (in_flash && !in_pwrite) state_d = ST_W_DIV;
          else                            state_d = ST_ERR;
        end
      end
      ST_PASS: begin
        req_active = 1'b1;
        req        = '{adr: addr_q[4:0], dat: wdata_q, we: write_q, sel: strb_q};
        if (req_done) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          prdata_d  = req_rdata;
          pslverr_d = req_err;
        end
      end
      ST_ERR: begin
        state_d   = ST_RESP;
        pready_d  = 1'b1;
        pslverr_d = 1'b1;
      end
      ST_W_DIV: begin
        req_active = 1'b1;
        req        = '{adr: REG_DIV, dat: XIP_DIV, we: 1'b1, sel: 4'hf};
        if (req_done) begin
          err_d   = req_err;
          state_d = req_err ? ST_W_SSOFF : ST_W_SS;
        end
      end
      ST_W_SS: begin
        req_active = 1'b1;
        req        = '{adr: REG_SS, dat: {24'h0, XIP_SS}, we: 1'b1, sel: 4'hf};
        if (req_done) begin
          err_d   = req_err;
          state_d = req_err ? ST_W_SSOFF : ST_W_TX1;
        end
      end
      ST_W_TX1: begin
        req_active = 1'b1;
        req        = '{adr: REG_TX1, dat: {FLASH_READ_CMD, addr_q[23:2], 2'b00}, we: 1'b1, sel: 4'hf};
        if (req_done) begin
          err_d   = req_err;
          state_d = req_err ? ST_W_SSOFF : ST_W_TX0;
        end
      end
      ST_W_TX0: begin
        req_active = 1'b1;
        req        = '{adr: REG_TX0, dat: 32'h0, we: 1'b1, sel: 4'hf};
        if (req_done) begin
          err_d   = req_err;
          state_d = req_err ? ST_W_SSOFF : ST_W_GO;
        end
      end
      ST_W_GO: begin
        req_active = 1'b1;
        req        = '{adr: REG_CTRL, dat: XIP_CTRL, we: 1'b1, sel: 4'hf};
        if (req_done) begin
          err_d   = req_err;
          state_d = req_err ? ST_W_SSOFF : ST_POLL;
        end
      end
      ST_POLL: begin
        req_active = 1'b1;
        req        = '{adr: REG_CTRL, dat: 32'h0, we: 1'b0, sel: 4'hf};
        if (req_done) begin
          if (req_err) begin
            err_d   = 1'b1;
            state_d = ST_W_SSOFF;
          end else if (!req_rdata[CTRL_GO_BIT]) begin
            state_d = ST_R_RX;
          end else if (poll_cnt_q == POLL_LAST) begin
            // Transfer never finished: give up, but still release the flash.
            err_d   = 1'b1;
            state_d = ST_W_SSOFF;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
          end
        end
      end
      ST_R_RX: begin
        req_active = 1'b1;
        req        = '{adr: REG_RX0, dat: 32'h0, we: 1'b0, sel: 4'hf};
        if (req_done) begin
          data_d  = byte_swap(req_rdata);
          err_d   = req_err;
          state_d = ST_W_SSOFF;
        end
      end
      ST_W_SSOFF: begin
        req_active = 1'b1;
        req        = '{adr: REG_SS, dat: 32'h0, we: 1'b1, sel: 4'hf};
        if (req_done) begin
          state_d   = ST_RESP;
          pready_d  = 1'b1;
          pslverr_d = err_q | req_err;
          prdata_d  = (err_q | req_err) ? 32'h0 : data_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and APB response registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      pready_q   <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      write_q    <= write_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      data_q     <= data_d;
      pready_q   <= pready_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
    end
  end

  assign in_pready  = pready_q;
  assign in_prdata  = prdata_q;
  assign in_pslverr = pslverr_q;

  spi_xip_wb_req u_wb_req (
    .clock     (clock),
    .reset     (reset),
    .start_i   (req_active && !req_busy),
    .req_adr_i (req.adr),
    .req_dat_i (req.dat),
    .req_we_i  (req.we),
    .req_sel_i (req.sel),
    .busy_o    (req_busy),
    .done_o    (req_done),
    .err_o     (req_err),
    .rdata_o   (req_rdata),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i)
  );

endmodule
